// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch/decode pipeline types and constants
// Purpose: NOP encoding and the fetch packet type used by the fetch queue
//          and by the decode stage input register.
// Ports:   none (package)
package pipeline_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - packet storage for the fetch queue
// Purpose: DEPTH x fetch_pkt_t array, one synchronous write port and one
//          asynchronous read port. Contents are never reset.
// Ports:   clk           rising-edge clock
//          i_we          write enable
//          i_waddr       write index
//          i_wdata       packet to write
//          i_raddr       read index
//          o_rdata       packet at i_raddr (combinational)
module fetch_queue_ram
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_pkt_t    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_pkt_t    o_rdata
);

    fetch_pkt_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling FIFO with single-cycle flush
// Purpose: buffers fetched packets so fetch can run ahead of a stalled
//          decode; presents the oldest packet with valid/ready. A taken
//          branch (flush) empties the queue at the next edge.
// Ports:   clk, reset                     clock, async active-low reset
//          in_valid/in_ready              fetch-side handshake
//          in_instr/in_pc/in_pc4          fetched packet
//          flush                          taken-branch redirect from execute
//          out_valid/out_ready            decode-side handshake
//          out_instr/out_pc/out_pc4       head packet (NOP/0/0 when empty)
//          count                          occupied entries, 0..DEPTH
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_pc4,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc4,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic       w_push;
    logic       w_pop;
    fetch_pkt_t w_wdata;
    fetch_pkt_t w_rdata;

    // in_ready looks only at registered occupancy: no pass-through when full.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    // Flush overrides both handshakes; neither side sees a transfer.
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    assign w_wdata = '{instr: in_instr, pc: in_pc, pc4: in_pc4};

    fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stale storage is masked so decode sees a clean bubble when empty.
    always_comb begin
        out_instr = NOP_INSTR;
        out_pc    = '0;
        out_pc4   = '0;
        if (out_valid) begin
            out_instr = w_rdata.instr;
            out_pc    = w_rdata.pc;
            out_pc4   = w_rdata.pc4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Instruction word is derived from pc so instr/pc4 pairing is checkable.
    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins_of(pc);
        in_pc4    = pc + 32'd4;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"},    out_pc,    pc);
        chk({tag, "_instr"}, out_instr, ins_of(pc));
        chk({tag, "_pc4"},   out_pc4,   pc + 32'd4);
    endtask

    initial begin
        logic [31:0] exp_pcs [4];

        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd1);
        chk("rst_count", {29'd0, count},     32'd0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_pc",    out_pc,    32'd0);
        chk("rst_pc4",   out_pc4,   32'd0);
        reset = 1'b1;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_count", {29'd0, count},     32'd0);
        chk("idle_instr", out_instr, 32'h0000_0013);

        // Fill to DEPTH with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            tick();
            chk("fill_count", {29'd0, count}, 32'(i + 1));
            chk("fill_head",  out_pc, 32'h0);
        end
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_head",  out_pc, 32'h0);

        // Pop two, then push two across the pointer wrap.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        chk("pop2_count", {29'd0, count}, 32'd2);
        chk("pop2_head",  out_pc, 32'h08);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        tick();
        chk("wrap_count", {29'd0, count}, 32'd4);
        exp_pcs = '{32'h08, 32'h0C, 32'h10, 32'h14};
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_head("drain", exp_pcs[i]);
            tick();
        end
        chk("drain_count", {29'd0, count}, 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_instr", out_instr, 32'h0000_0013);

        // Streaming: one push and one pop per cycle.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h100 + 32'(k * 4), 1'b1, 1'b0);
            tick();
            chk("stream_count", {29'd0, count}, 32'd1);
            chk("stream_pc", out_pc, 32'h100 + 32'(k * 4));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("stream_end", {29'd0, count}, 32'd0);

        // Flush at count 3 with push and pop in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        chk("pre_flush_count", {29'd0, count}, 32'd3);
        drive(1'b1, 32'h20C, 1'b1, 1'b1);
        tick();
        chk("flush_count", {29'd0, count},     32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready},  32'd1);
        chk("flush_pc",    out_pc, 32'd0);
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        chk("post_flush_count", {29'd0, count}, 32'd1);
        chk_head("post_flush", 32'h300);

        // Asynchronous reset mid-cycle at count 2.
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_arst_count", {29'd0, count}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {29'd0, count},     32'd0);
        chk("arst_instr", out_instr, 32'h0000_0013);
        #3;
        reset = 1'b1;
        tick();
        chk("post_arst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_arst_ready", {31'd0, in_ready},  32'd1);
        chk("post_arst_count", {29'd0, count},     32'd0);
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        tick();
        chk_head("post_arst_push", 32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
